// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single-port memory between the CPU and a debug/loader port.
// CPU has priority, debug is protected by a starvation bound, and a turnaround cycle separates owners after a write.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned BURST_LEN    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [15:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic [15:0] dbg_rdata,
  output logic        dbg_rvalid,
  output logic [15:0] mem_addr,
  output logic        mem_re_L,
  output logic        mem_we_L,
  output logic [15:0] mem_wdata,
  output logic        mem_wdrv,
  input  logic [15:0] mem_rdata
);
  typedef enum logic [1:0] {S_IDLE, S_CPU, S_DBG, S_TURN} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG} own_e;

  localparam logic [7:0] STARVE_L = 8'(STARVE_LIMIT);
  localparam logic [7:0] BURST_L  = 8'(BURST_LEN);

  state_e      state_q, state_d;
  own_e        wr_own_q, wr_own_d;
  logic [7:0]  starve_q, starve_d;
  logic [7:0]  burst_q, burst_d;
  logic [15:0] dbg_rdata_q, dbg_rdata_d;
  logic        dbg_rvalid_q, dbg_rvalid_d;

  own_e win;
  logic turn, cpu_gnt, dbg_gnt_w;

  always_comb begin
    win = OWN_NONE;
    if (!reset) begin
      if (dbg_req && starve_q == STARVE_L)                      win = OWN_DBG;
      else if (state_q == S_DBG && burst_q < BURST_L && dbg_req) win = OWN_DBG;
      else if (cpu_req)                                         win = OWN_CPU;
      else if (dbg_req)                                         win = OWN_DBG;
    end
    // A write leaves the bus driven by its owner; the other side must wait one cycle.
    turn      = (win != OWN_NONE) && (wr_own_q != OWN_NONE) && (wr_own_q != win);
    cpu_gnt   = (win == OWN_CPU) && !turn;
    dbg_gnt_w = (win == OWN_DBG) && !turn;

    mem_addr  = 16'h0;
    mem_wdata = 16'h0;
    mem_re_L  = 1'b1;
    mem_we_L  = 1'b1;
    mem_wdrv  = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_re_L  = cpu_we;
      mem_we_L  = !cpu_we;
      mem_wdrv  = cpu_we;
    end else if (dbg_gnt_w) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_re_L  = dbg_we;
      mem_we_L  = !dbg_we;
      mem_wdrv  = dbg_we;
    end

    state_d = turn ? S_TURN : cpu_gnt ? S_CPU : dbg_gnt_w ? S_DBG : S_IDLE;
    wr_own_d = OWN_NONE;
    if (cpu_gnt && cpu_we)     wr_own_d = OWN_CPU;
    if (dbg_gnt_w && dbg_we)   wr_own_d = OWN_DBG;

    starve_d = starve_q;
    if (!dbg_req || dbg_gnt_w)  starve_d = 8'd0;
    else if (starve_q < STARVE_L) starve_d = starve_q + 8'd1;

    burst_d = 8'd0;
    if (dbg_gnt_w) begin
      if (state_q != S_DBG)      burst_d = 8'd1;
      else if (burst_q < BURST_L) burst_d = burst_q + 8'd1;
      else                       burst_d = burst_q;
    end

    dbg_rvalid_d = dbg_gnt_w && !dbg_we;
    dbg_rdata_d  = dbg_rvalid_d ? mem_rdata : dbg_rdata_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_own_q     <= OWN_NONE;
      starve_q     <= 8'd0;
      burst_q      <= 8'd0;
      dbg_rdata_q  <= 16'h0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_own_q     <= wr_own_d;
      starve_q     <= starve_d;
      burst_q      <= burst_d;
      dbg_rdata_q  <= dbg_rdata_d;
      dbg_rvalid_q <= dbg_rvalid_d;
    end
  end

  assign cpu_stall  = cpu_req && !cpu_gnt;
  assign dbg_gnt    = dbg_gnt_w;
  assign dbg_rdata  = dbg_rdata_q;
  assign dbg_rvalid = dbg_rvalid_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a small behavioural memory on the bus.
module tb_mem_bus_arbiter;
  logic        clock = 1'b0, reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_stall, dbg_gnt, dbg_rvalid;
  logic [15:0] dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_re_L, mem_we_L, mem_wdrv;
  logic [15:0] mem [0:1023];
  int n_chk = 0, n_err = 0;

  mem_bus_arbiter #(.STARVE_LIMIT(8), .BURST_LEN(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
    .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .mem_addr(mem_addr), .mem_re_L(mem_re_L), .mem_we_L(mem_we_L), .mem_wdata(mem_wdata),
    .mem_wdrv(mem_wdrv), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  assign mem_rdata = mem_re_L ? 16'h0 : mem[mem_addr[9:0]];
  always @(posedge clock) if (!mem_we_L && mem_wdrv) mem[mem_addr[9:0]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic cyc_chk(input string tag, input logic gnt, input logic stall);
    @(negedge clock);
    chk({tag, " dbg_gnt"}, 32'(dbg_gnt), 32'(gnt));
    chk({tag, " cpu_stall"}, 32'(cpu_stall), 32'(stall));
    tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    mem[10'h010] = 16'h1234;
    mem[10'h300] = 16'h00A5;
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_wdata = 16'h0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 16'h0;   dbg_wdata = 16'h0;
    @(negedge clock);
    chk("rst mem_re_L", 32'(mem_re_L), 32'(1));
    chk("rst mem_we_L", 32'(mem_we_L), 32'(1));
    chk("rst mem_wdrv", 32'(mem_wdrv), 32'(0));
    chk("rst cpu_stall", 32'(cpu_stall), 32'(1));
    chk("rst dbg_rvalid", 32'(dbg_rvalid), 32'(0));
    chk("rst dbg_rdata", 32'(dbg_rdata), 32'(0));
    tick(); reset = 1'b0;

    // 1: lone CPU read, repeated without turnaround
    @(negedge clock);
    chk("t1 mem_re_L", 32'(mem_re_L), 32'(0));
    chk("t1 mem_addr", 32'(mem_addr), 32'h0010);
    chk("t1 rdata", 32'(mem_rdata), 32'h1234);
    chk("t1 cpu_stall", 32'(cpu_stall), 32'(0));
    tick();
    @(negedge clock);
    chk("t1 repeat re_L", 32'(mem_re_L), 32'(0));
    chk("t1 repeat stall", 32'(cpu_stall), 32'(0));
    tick();

    // 2: contention, dbg forced through after 8 denied cycles
    dbg_req = 1'b1; dbg_addr = 16'h0300;
    for (int c = 1; c <= 8; c++) cyc_chk("t2 cpu phase", 1'b0, 1'b0);
    @(negedge clock);
    chk("t2 starve gnt", 32'(dbg_gnt), 32'(1));
    chk("t2 starve stall", 32'(cpu_stall), 32'(1));
    chk("t2 starve addr", 32'(mem_addr), 32'h0300);
    tick(); dbg_req = 1'b0;
    @(negedge clock);
    chk("t2 cpu resumes", 32'(cpu_stall), 32'(0));
    chk("t2 rvalid", 32'(dbg_rvalid), 32'(1));
    chk("t2 rdata", 32'(dbg_rdata), 32'h00A5);
    tick(); cpu_req = 1'b0; tick();

    // 3: dbg write followed by CPU read needs one turnaround
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0200; dbg_wdata = 16'hBEEF;
    @(negedge clock);
    chk("t3 wr gnt", 32'(dbg_gnt), 32'(1));
    chk("t3 wr we_L", 32'(mem_we_L), 32'(0));
    chk("t3 wr wdrv", 32'(mem_wdrv), 32'(1));
    chk("t3 wr data", 32'(mem_wdata), 32'hBEEF);
    tick();
    dbg_req = 1'b0; dbg_we = 1'b0; cpu_req = 1'b1; cpu_addr = 16'h0200;
    @(negedge clock);
    chk("t3 turn re_L", 32'(mem_re_L), 32'(1));
    chk("t3 turn we_L", 32'(mem_we_L), 32'(1));
    chk("t3 turn stall", 32'(cpu_stall), 32'(1));
    chk("t3 turn addr", 32'(mem_addr), 32'h0);
    tick();
    @(negedge clock);
    chk("t3 rd re_L", 32'(mem_re_L), 32'(0));
    chk("t3 rd stall", 32'(cpu_stall), 32'(0));
    chk("t3 rd data", 32'(mem_rdata), 32'hBEEF);
    tick(); cpu_req = 1'b0; tick();

    // 4a: uncontended burst runs past BURST_LEN
    dbg_req = 1'b1; dbg_addr = 16'h0300;
    for (int c = 1; c <= 6; c++) cyc_chk("t4a burst", 1'b1, 1'b0);
    dbg_req = 1'b0; tick();

    // 4b: CPU raised at read 2, gets the slot after 4 dbg grants
    dbg_req = 1'b1; cpu_addr = 16'h0010;
    cyc_chk("t4b read1", 1'b1, 1'b0);
    cpu_req = 1'b1;
    for (int c = 2; c <= 4; c++) cyc_chk("t4b held", 1'b1, 1'b1);
    cyc_chk("t4b cpu slot", 1'b0, 1'b0);
    cpu_req = 1'b0;
    cyc_chk("t4b resume5", 1'b1, 1'b0);
    cyc_chk("t4b resume6", 1'b1, 1'b0);
    dbg_req = 1'b0; tick();

    // 5: read-data pulse timing
    dbg_req = 1'b1; dbg_addr = 16'h0300;
    mem[10'h300] = 16'h00A5;
    @(negedge clock);
    chk("t5 gnt", 32'(dbg_gnt), 32'(1));
    chk("t5 rvalid N", 32'(dbg_rvalid), 32'(0));
    tick(); dbg_req = 1'b0;
    @(negedge clock);
    chk("t5 rvalid N+1", 32'(dbg_rvalid), 32'(1));
    chk("t5 rdata N+1", 32'(dbg_rdata), 32'h00A5);
    tick();
    @(negedge clock);
    chk("t5 rvalid N+2", 32'(dbg_rvalid), 32'(0));
    tick();

    // 6a: reset with a partial starvation count
    cpu_req = 1'b1; dbg_req = 1'b1;
    repeat (5) tick();
    chk("t6 starve pre", 32'(dut.starve_q), 32'd5);
    #2 reset = 1'b1; #1;
    chk("t6 starve rst", 32'(dut.starve_q), 32'd0);
    chk("t6 rst stall", 32'(cpu_stall), 32'(1));
    chk("t6 rst gnt", 32'(dbg_gnt), 32'(0));
    tick(); cpu_req = 1'b0; tick(); reset = 1'b0;

    // 6b: reset mid write-burst, then CPU read must not see a turnaround
    dbg_we = 1'b1; dbg_addr = 16'h0204; dbg_wdata = 16'h5A5A;
    cyc_chk("t6 burst1", 1'b1, 1'b0);
    cyc_chk("t6 burst2", 1'b1, 1'b0);
    chk("t6 burst pre", 32'(dut.burst_q), 32'd2);
    #2 reset = 1'b1; #1;
    chk("t6 burst rst", 32'(dut.burst_q), 32'd0);
    chk("t6 rst we_L", 32'(mem_we_L), 32'(1));
    chk("t6 rst wdrv", 32'(mem_wdrv), 32'(0));
    chk("t6 rst dbg_gnt", 32'(dbg_gnt), 32'(0));
    dbg_req = 1'b0; dbg_we = 1'b0;
    tick(); reset = 1'b0;
    cpu_req = 1'b1; cpu_addr = 16'h0010;
    @(negedge clock);
    chk("t6 post re_L", 32'(mem_re_L), 32'(0));
    chk("t6 post stall", 32'(cpu_stall), 32'(0));
    chk("t6 post rdata", 32'(mem_rdata), 32'h1234);
    tick(); cpu_req = 1'b0; tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
